// File: rtl/room_sequencer.sv
// room_sequencer
//   Owns the current room coordinates (mapX/mapY) that drive the map
//   generator. Once per frame it samples the player position, detects a
//   screen-edge crossing, steps to the neighbouring room when that room
//   exists, re-places the player just inside the opposite edge and blanks
//   the display for BLANK_FRAMES frames.
//
// Ports
//   clk_vga     in   VGA pixel clock (only clock)
//   reset       in   asynchronous, active-high reset
//   frame_tick  in   one-cycle pulse at start of vertical blank
//   playerX     in   player X position (10 bits)
//   playerY     in   player Y position (9 bits)
//   respawn     in   one-cycle pulse; return to the start room
//   mapX        out  current room X (+1 = east)
//   mapY        out  current room Y (+1 = south)
//   player_load out  one-cycle pulse; player logic loads loadX/loadY
//   loadX       out  new player X
//   loadY       out  new player Y
//   blank       out  high during a room transition
//   blocked     out  one-cycle pulse; edge reached but no neighbour room
module room_sequencer #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int EDGE         = 8,
  parameter int ENTRY_MARGIN = 24,
  parameter int BLANK_FRAMES = 2,
  parameter int START_X      = 320,
  parameter int START_Y      = 240
) (
  input  logic       clk_vga,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [9:0] playerX,
  input  logic [8:0] playerY,
  input  logic       respawn,
  output logic [3:0] mapX,
  output logic [3:0] mapY,
  output logic       player_load,
  output logic [9:0] loadX,
  output logic [8:0] loadY,
  output logic       blank,
  output logic       blocked
);

  localparam int CW = (BLANK_FRAMES < 2) ? 1 : $clog2(BLANK_FRAMES + 1);

  localparam logic [9:0] X_W_LIM   = 10'(EDGE);
  localparam logic [9:0] X_E_LIM   = 10'(SCREEN_W - 1 - EDGE);
  localparam logic [8:0] Y_N_LIM   = 9'(EDGE);
  localparam logic [8:0] Y_S_LIM   = 9'(SCREEN_H - 1 - EDGE);
  localparam logic [9:0] X_ENTRY_W = 10'(SCREEN_W - ENTRY_MARGIN);
  localparam logic [9:0] X_ENTRY_E = 10'(ENTRY_MARGIN);
  localparam logic [8:0] Y_ENTRY_N = 9'(SCREEN_H - ENTRY_MARGIN);
  localparam logic [8:0] Y_ENTRY_S = 9'(ENTRY_MARGIN);
  localparam logic [9:0] X_START   = 10'(START_X);
  localparam logic [8:0] Y_START   = 9'(START_Y);
  localparam logic [3:0] MAP_X0    = 4'd3;
  localparam logic [3:0] MAP_Y0    = 4'd5;
  localparam logic [CW-1:0] CNT_LOAD = CW'(BLANK_FRAMES);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    LOAD,
    BLANK
  } state_t;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_N,
    DIR_S,
    DIR_W,
    DIR_E
  } dir_t;

  state_t        state_q, state_d;
  logic [9:0]    px_q, px_d;
  logic [8:0]    py_q, py_d;
  logic [3:0]    mapx_q, mapx_d;
  logic [3:0]    mapy_q, mapy_d;
  logic [9:0]    loadx_q, loadx_d;
  logic [8:0]    loady_q, loady_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          player_load_q, player_load_d;
  logic          blank_q, blank_d;
  logic          blocked_q, blocked_d;

  dir_t          dir;
  logic [3:0]    nbr_x;
  logic [3:0]    nbr_y;

  // The world map: fixed set of rooms that exist.
  function automatic logic room_valid(input logic [3:0] x, input logic [3:0] y);
    case ({x, y})
      8'h35, 8'h36, 8'h46, 8'h47, 8'h26, 8'h16,
      8'h24, 8'h25, 8'h15, 8'h14, 8'h13, 8'h12: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  // Edge detection on the sampled position. Only the highest-priority
  // edge (N > S > W > E) is considered; neighbour wraps mod 16.
  always_comb begin
    dir   = DIR_NONE;
    nbr_x = mapx_q;
    nbr_y = mapy_q;
    if (py_q < Y_N_LIM) begin
      dir   = DIR_N;
      nbr_y = mapy_q - 4'd1;
    end else if (py_q > Y_S_LIM) begin
      dir   = DIR_S;
      nbr_y = mapy_q + 4'd1;
    end else if (px_q < X_W_LIM) begin
      dir   = DIR_W;
      nbr_x = mapx_q - 4'd1;
    end else if (px_q > X_E_LIM) begin
      dir   = DIR_E;
      nbr_x = mapx_q + 4'd1;
    end
  end

  always_comb begin
    state_d       = state_q;
    px_d          = px_q;
    py_d          = py_q;
    mapx_d        = mapx_q;
    mapy_d        = mapy_q;
    loadx_d       = loadx_q;
    loady_d       = loady_q;
    cnt_d         = cnt_q;
    player_load_d = 1'b0;
    blank_d       = 1'b0;
    blocked_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          px_d    = playerX;
          py_d    = playerY;
          state_d = EVAL;
        end
      end

      EVAL: begin
        if (dir == DIR_NONE) begin
          state_d = IDLE;
        end else if (!room_valid(nbr_x, nbr_y)) begin
          blocked_d = 1'b1;
          state_d   = IDLE;
        end else begin
          mapx_d  = nbr_x;
          mapy_d  = nbr_y;
          loadx_d = px_q;
          loady_d = py_q;
          case (dir)
            DIR_N:   loady_d = Y_ENTRY_N;
            DIR_S:   loady_d = Y_ENTRY_S;
            DIR_W:   loadx_d = X_ENTRY_W;
            DIR_E:   loadx_d = X_ENTRY_E;
            default: ;
          endcase
          state_d = LOAD;
        end
      end

      LOAD: begin
        player_load_d = 1'b1;
        blank_d       = 1'b1;
        cnt_d         = CNT_LOAD;
        state_d       = (BLANK_FRAMES == 0) ? IDLE : BLANK;
      end

      BLANK: begin
        blank_d = 1'b1;
        if (frame_tick) begin
          // <= 1 rather than == 1 so a zero count can never get stuck.
          if (cnt_q <= CW'(1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Respawn overrides whatever the state logic decided this cycle;
    // going through LOAD also restarts any blanking in progress.
    if (respawn) begin
      mapx_d    = MAP_X0;
      mapy_d    = MAP_Y0;
      loadx_d   = X_START;
      loady_d   = Y_START;
      blocked_d = 1'b0;
      state_d   = LOAD;
    end
  end

  always_ff @(posedge clk_vga or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      px_q          <= '0;
      py_q          <= '0;
      mapx_q        <= MAP_X0;
      mapy_q        <= MAP_Y0;
      loadx_q       <= X_START;
      loady_q       <= Y_START;
      cnt_q         <= '0;
      player_load_q <= 1'b0;
      blank_q       <= 1'b0;
      blocked_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      px_q          <= px_d;
      py_q          <= py_d;
      mapx_q        <= mapx_d;
      mapy_q        <= mapy_d;
      loadx_q       <= loadx_d;
      loady_q       <= loady_d;
      cnt_q         <= cnt_d;
      player_load_q <= player_load_d;
      blank_q       <= blank_d;
      blocked_q     <= blocked_d;
    end
  end

  assign mapX        = mapx_q;
  assign mapY        = mapy_q;
  assign player_load = player_load_q;
  assign loadX       = loadx_q;
  assign loadY       = loady_q;
  assign blank       = blank_q;
  assign blocked     = blocked_q;

endmodule

// File: tb/tb_room_sequencer.sv
// tb_room_sequencer
//   Directed bench for room_sequencer: reset values, room moves with
//   latency checks, blocked edges, edge priority, threshold boundaries,
//   blanking duration and respawn during blanking.
module tb_room_sequencer;

  logic       clk_vga;
  logic       reset;
  logic       frame_tick;
  logic [9:0] playerX;
  logic [8:0] playerY;
  logic       respawn;
  logic [3:0] mapX;
  logic [3:0] mapY;
  logic       player_load;
  logic [9:0] loadX;
  logic [8:0] loadY;
  logic       blank;
  logic       blocked;

  int n_tests = 0;
  int n_fail  = 0;

  room_sequencer #(
    .SCREEN_W    (640),
    .SCREEN_H    (480),
    .EDGE        (8),
    .ENTRY_MARGIN(24),
    .BLANK_FRAMES(2),
    .START_X     (320),
    .START_Y     (240)
  ) dut (
    .clk_vga    (clk_vga),
    .reset      (reset),
    .frame_tick (frame_tick),
    .playerX    (playerX),
    .playerY    (playerY),
    .respawn    (respawn),
    .mapX       (mapX),
    .mapY       (mapY),
    .player_load(player_load),
    .loadX      (loadX),
    .loadY      (loadY),
    .blank      (blank),
    .blocked    (blocked)
  );

  initial clk_vga = 1'b0;
  always #5 clk_vga = ~clk_vga;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_vga);
    #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
  endtask

  // Drive a position, tick, and land on the cycle where player_load shows.
  task automatic move(input logic [9:0] x, input logic [8:0] y);
    playerX = x;
    playerY = y;
    pulse_tick();
    cyc(2);
  endtask

  // Let two blanking ticks pass with the player mid-screen.
  task automatic finish_blank(input string tag);
    playerX = 10'd320;
    playerY = 9'd240;
    cyc(2);
    pulse_tick();
    cyc(2);
    check({tag, "_blank_mid"}, 32'(blank), 32'd1);
    pulse_tick();
    cyc(2);
    check({tag, "_blank_end"}, 32'(blank), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    frame_tick = 1'b0;
    respawn    = 1'b0;
    playerX    = 10'd320;
    playerY    = 9'd240;
    cyc(2);

    check("rst_mapX", 32'(mapX), 32'd3);
    check("rst_mapY", 32'(mapY), 32'd5);
    check("rst_blank", 32'(blank), 32'd0);
    check("rst_pload", 32'(player_load), 32'd0);
    check("rst_loadX", 32'(loadX), 32'd320);
    check("rst_loadY", 32'(loadY), 32'd240);
    check("rst_blocked", 32'(blocked), 32'd0);

    reset = 1'b0;
    cyc(1);

    // Threshold boundaries: X=631 and Y=8 are still inside the screen.
    playerX = 10'd631;
    playerY = 9'd8;
    pulse_tick();
    cyc(1);
    check("bnd_blocked", 32'(blocked), 32'd0);
    cyc(1);
    check("bnd_pload", 32'(player_load), 32'd0);
    check("bnd_mapX", 32'(mapX), 32'd3);
    check("bnd_blank", 32'(blank), 32'd0);

    // East from (3,5) at X=632 -> (4,5) does not exist.
    playerX = 10'd632;
    playerY = 9'd240;
    pulse_tick();
    cyc(1);
    check("e_blocked", 32'(blocked), 32'd1);
    check("e_mapX", 32'(mapX), 32'd3);
    check("e_mapY", 32'(mapY), 32'd5);
    cyc(1);
    check("e_blocked_end", 32'(blocked), 32'd0);
    check("e_pload", 32'(player_load), 32'd0);
    check("e_blank", 32'(blank), 32'd0);

    // South from (3,5): map updates 2 cycles after the tick, load 3.
    playerX = 10'd100;
    playerY = 9'd500;
    pulse_tick();
    check("s_mapY_eval", 32'(mapY), 32'd5);
    cyc(1);
    check("s_mapY", 32'(mapY), 32'd6);
    check("s_mapX", 32'(mapX), 32'd3);
    check("s_pload_early", 32'(player_load), 32'd0);
    cyc(1);
    check("s_pload", 32'(player_load), 32'd1);
    check("s_loadY", 32'(loadY), 32'd24);
    check("s_loadX", 32'(loadX), 32'd100);
    check("s_blank", 32'(blank), 32'd1);
    cyc(1);
    check("s_pload_end", 32'(player_load), 32'd0);
    finish_blank("s");

    // N and W both hit in (3,6): N wins.
    move(10'd2, 9'd2);
    check("nw_mapX", 32'(mapX), 32'd3);
    check("nw_mapY", 32'(mapY), 32'd5);
    check("nw_pload", 32'(player_load), 32'd1);
    check("nw_loadY", 32'(loadY), 32'd456);
    check("nw_loadX", 32'(loadX), 32'd2);
    finish_blank("nw");

    // Back to (3,6), then west twice, then a blocked west.
    move(10'd320, 9'd472);
    check("s2_mapY", 32'(mapY), 32'd6);
    finish_blank("s2");
    move(10'd7, 9'd200);
    check("w1_mapX", 32'(mapX), 32'd2);
    check("w1_loadX", 32'(loadX), 32'd616);
    check("w1_loadY", 32'(loadY), 32'd200);
    finish_blank("w1");
    move(10'd0, 9'd240);
    check("w2_mapX", 32'(mapX), 32'd1);
    check("w2_mapY", 32'(mapY), 32'd6);
    finish_blank("w2");

    playerX = 10'd3;
    playerY = 9'd240;
    pulse_tick();
    cyc(1);
    check("w3_blocked", 32'(blocked), 32'd1);
    check("w3_mapX", 32'(mapX), 32'd1);
    cyc(1);
    check("w3_pload", 32'(player_load), 32'd0);

    // North three times: (1,6) -> (1,5) -> (1,4) -> (1,3).
    move(10'd320, 9'd2);
    check("n1_mapY", 32'(mapY), 32'd5);
    check("n1_loadY", 32'(loadY), 32'd456);
    finish_blank("n1");
    move(10'd320, 9'd7);
    check("n2_mapY", 32'(mapY), 32'd4);
    finish_blank("n2");
    move(10'd320, 9'd0);
    check("n3_mapY", 32'(mapY), 32'd3);
    check("n3_mapX", 32'(mapX), 32'd1);
    finish_blank("n3");

    // South to (1,4), then respawn part-way through the blanking.
    move(10'd50, 9'd511);
    check("s3_mapY", 32'(mapY), 32'd4);
    check("s3_loadY", 32'(loadY), 32'd24);
    playerX = 10'd320;
    playerY = 9'd240;
    cyc(1);
    pulse_tick();
    respawn = 1'b1;
    cyc(1);
    respawn = 1'b0;
    check("rsp_mapX", 32'(mapX), 32'd3);
    check("rsp_mapY", 32'(mapY), 32'd5);
    check("rsp_loadX", 32'(loadX), 32'd320);
    check("rsp_loadY", 32'(loadY), 32'd240);
    cyc(1);
    check("rsp_pload", 32'(player_load), 32'd1);
    check("rsp_blank", 32'(blank), 32'd1);
    cyc(1);
    check("rsp_pload_end", 32'(player_load), 32'd0);
    pulse_tick();
    cyc(2);
    check("rsp_blank_t1", 32'(blank), 32'd1);
    pulse_tick();
    cyc(2);
    check("rsp_blank_t2", 32'(blank), 32'd0);
    check("rsp_mapX_end", 32'(mapX), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
